bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 111 +++++++++++
 tb/tb_bit_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter, MSB first, with a
// valid/ready handshake on the parallel side. Back-to-back frames are
// emitted without a gap when a new word is offered in the final bit cycle.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends one even-parity
// bit after data bit 0. The port list is the same in both builds.
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  // Data bits still to be emitted after the first one, loaded on handshake.
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e            state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [CntW-1:0]   cnt_q;
  logic              last_data;
  logic              final_bit;
  logic              accept;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  // Final-bit detection and the combinational ready/handshake.
  always_comb begin
    last_data = (state_q == StShift) && (cnt_q == '0);
`ifdef BIT_SERIALIZER_PARITY_EN
    final_bit = (state_q == StParity);
`else
    final_bit = last_data;
`endif
    din_ready = (state_q == StIdle) || final_bit;
    accept    = din_valid && din_ready;
  end

  // Frame FSM with registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (accept) begin
      // MSB goes straight to the output; the rest waits left-aligned.
      state_q   <= StShift;
      shreg_q   <= {din[WIDTH-2:0], 1'b0};
      cnt_q     <= CntLoad;
      out       <= din[WIDTH-1];
      out_valid <= 1'b1;
      done      <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q     <= ^din;
`endif
    end else begin
      case (state_q)
        StShift: begin
          if (!last_data) begin
            out     <= shreg_q[WIDTH-1];
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - CntOne;
`ifdef BIT_SERIALIZER_PARITY_EN
            done    <= 1'b0;
`else
            done    <= (cnt_q == CntOne);
`endif
          end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
            state_q <= StParity;
            out     <= par_q;
            done    <= 1'b1;
`else
            state_q   <= StIdle;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`endif
          end
        end
        default: begin
          // Idle, or end of the parity cycle with no follow-on word.
          state_q   <= StIdle;
          out       <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench with a bit-level scoreboard. Each accepted
// word pushes its expected serial bits (and done flags) into a queue; a
// negedge monitor pops and compares whenever out_valid is high.
module tb_bit_serializer;

  localparam int unsigned W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int FrameLen = ParEn ? W + 1 : W;

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         out;
  logic         out_valid;
  logic         done;

  exp_t q[$];
  int   n_cmp;
  int   n_err;
  logic [2:0] hist;
  int   hist_len;
  int   det_cnt;

  bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e.b = w[i];
      e.d = (i == 0) && !ParEn;
      q.push_back(e);
    end
    if (ParEn) begin
      e.b = ^w;
      e.d = 1'b1;
      q.push_back(e);
    end
  endtask

  // Called at a negedge where din_ready must be 1; returns one cycle later.
  task automatic offer(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    chk("ready_at_offer", 32'(din_ready), 32'd1);
    push_frame(w);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Scoreboard monitor plus a 101 detector model on the valid bit stream.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_bit", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("out_bit", 32'(out), 32'(e.b));
        chk("done_flag", 32'(done), 32'(e.d));
      end
      hist = {hist[1:0], out};
      hist_len++;
      if (hist_len >= 3 && hist == 3'b101) det_cnt++;
    end else begin
      chk("idle_out", 32'(out), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    hist = '0;
    hist_len = 0;
    det_cnt = 0;
    rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(din_ready), 32'd1);
    end
    rst_n = 1'b1;

    // Single frame, handshake on the first edge after reset release.
    hist_len = 0;
    det_cnt = 0;
    offer(8'hA0);
    for (int i = 1; i < FrameLen; i++) begin
      chk("single_busy_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    chk("single_last_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    chk("single_idle_valid", 32'(out_valid), 32'd0);
    chk("single_idle_ready", 32'(din_ready), 32'd1);
    chk("detect_101_once", 32'(det_cnt), 32'd1);

    // Back-to-back frames with din_valid held high.
    din = 8'hA5;
    din_valid = 1'b1;
    chk("b2b_ready0", 32'(din_ready), 32'd1);
    push_frame(8'hA5);
    @(negedge clk);
    din = 8'h5A;
    for (int i = 1; i < FrameLen; i++) begin
      chk("b2b_valid_a", 32'(out_valid), 32'd1);
      chk("b2b_ready_busy", 32'(din_ready), 32'd0);
      @(negedge clk);
    end
    chk("b2b_ready_last", 32'(din_ready), 32'd1);
    push_frame(8'h5A);
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < FrameLen; i++) begin
      chk("b2b_valid_b", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    chk("b2b_idle_valid", 32'(out_valid), 32'd0);

    // Busy-time din/din_valid activity must be ignored.
    offer(8'h3C);
    for (int i = 1; i <= FrameLen - 2; i++) begin
      chk("busy_ready", 32'(din_ready), 32'd0);
      din = W'($urandom);
      din_valid = i[0];
      @(negedge clk);
    end
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle_valid", 32'(out_valid), 32'd0);
    chk("busy_queue_empty", 32'(q.size()), 32'd0);

    // Reset in the middle of a frame of all ones.
    offer(8'hFF);
    @(negedge clk);
    @(negedge clk);
    chk("mid_valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FrameLen; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_ready", 32'(din_ready), 32'd1);
    end

    // Parity frames (the scoreboard appends the parity bit when enabled).
    offer(8'h07);
    for (int i = 1; i < FrameLen; i++) @(negedge clk);
    offer(8'h03);
    for (int i = 1; i < FrameLen; i++) @(negedge clk);
    @(negedge clk);
    chk("final_idle_valid", 32'(out_valid), 32'd0);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
